// File: rtl/muxnx1_if.sv
// Bus bundle for the N-to-1 bit multiplexer.
//   muxnx1_port_sel : select index, $clog2(SIZE) bits
//   muxnx1_port_i   : SIZE-bit data vector, bit k is input k
//   muxnx1_port_out : registered selected bit
//   muxnx1_port_err : registered out-of-range select flag
// master drives sel/i and observes out/err; slave is the multiplexer side.
interface muxnx1_if #(
    parameter int unsigned SIZE = 16
);
    localparam int unsigned SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [SEL_W-1:0] muxnx1_port_sel;
    logic [SIZE-1:0]  muxnx1_port_i;
    logic             muxnx1_port_out;
    logic             muxnx1_port_err;

    modport master (
        output muxnx1_port_sel,
        output muxnx1_port_i,
        input  muxnx1_port_out,
        input  muxnx1_port_err
    );

    modport slave (
        input  muxnx1_port_sel,
        input  muxnx1_port_i,
        output muxnx1_port_out,
        output muxnx1_port_err
    );
endinterface

// File: rtl/muxnx1.sv
// Parameterised N-to-1 single-bit multiplexer with registered output.
//   muxnx1_port_clk : clock, rising edge
//   muxnx1_port_rst : synchronous active-high reset
//   bus (slave)     : sel/i in, out/err registered out (see muxnx1_if)
// The select path is a balanced 2:1 tree over the input vector padded with
// zeros up to the next power of two; out-of-range selects land on padding,
// so the output is 0 and the err flag is raised.
module muxnx1 #(
    parameter int unsigned SIZE = 16
) (
    input  logic        muxnx1_port_clk,
    input  logic        muxnx1_port_rst,
    muxnx1_if.slave     bus
);
    localparam int unsigned SEL_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned PAD   = 1 << SEL_W;

    // A single input has no meaningful select; refuse to elaborate.
    if (SIZE < 2) begin : g_size_check
        $error("muxnx1: SIZE must be at least 2");
    end

    // Heap-ordered tree: node 0 is the root, leaves sit at PAD-1 .. 2*PAD-2.
    logic [2*PAD-2:0] node_c;
    logic             range_err_c;

    // Leaf level, zero-padded beyond SIZE.
    for (genvar k = 0; k < PAD; k++) begin : g_leaf
        if (k < SIZE) begin : g_data
            assign node_c[PAD-1+k] = bus.muxnx1_port_i[k];
        end else begin : g_pad
            assign node_c[PAD-1+k] = 1'b0;
        end
    end

    // Internal nodes; nodes nearest the leaves use sel[0], the root uses the MSB.
    for (genvar n = 0; n < PAD - 1; n++) begin : g_node
        localparam int unsigned DEPTH = $clog2(n + 2) - 1;
        localparam int unsigned BIT   = SEL_W - 1 - DEPTH;
        assign node_c[n] = bus.muxnx1_port_sel[BIT] ? node_c[2*n+2] : node_c[2*n+1];
    end

    // Out-of-range is only reachable when SIZE is not a power of two.
    if (PAD != SIZE) begin : g_range_chk
        assign range_err_c = (32'(bus.muxnx1_port_sel) >= 32'(SIZE));
    end else begin : g_range_none
        assign range_err_c = 1'b0;
    end

    // Output registers; out and err update together.
    always_ff @(posedge muxnx1_port_clk) begin
        if (muxnx1_port_rst) begin
            bus.muxnx1_port_out <= 1'b0;
            bus.muxnx1_port_err <= 1'b0;
        end else begin
            bus.muxnx1_port_out <= node_c[0];
            bus.muxnx1_port_err <= range_err_c;
        end
    end
endmodule

// File: tb/tb_muxnx1.sv
// Directed testbench for muxnx1: one SIZE=16 instance and one SIZE=10
// instance sharing clock and reset.
module tb_muxnx1;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    muxnx1_if #(.SIZE(16)) bus16 ();
    muxnx1_if #(.SIZE(10)) bus10 ();

    muxnx1 #(.SIZE(16)) u_dut16 (
        .muxnx1_port_clk (clk),
        .muxnx1_port_rst (rst),
        .bus             (bus16.slave)
    );

    muxnx1 #(.SIZE(10)) u_dut10 (
        .muxnx1_port_clk (clk),
        .muxnx1_port_rst (rst),
        .bus             (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus16.muxnx1_port_i   = 16'hFFFF;
        bus16.muxnx1_port_sel = 4'd5;
        for (int e = 0; e < 2; e++) begin
            step();
            checks++;
            if (bus16.muxnx1_port_out !== 1'b0 || bus16.muxnx1_port_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_edge%0d: out=%b err=%b, want out=0 err=0",
                         e, bus16.muxnx1_port_out, bus16.muxnx1_port_err);
            end
        end
        checks++;
        if (bus10.muxnx1_port_out !== 1'b0 || bus10.muxnx1_port_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_size10: out=%b err=%b, want out=0 err=0",
                     bus10.muxnx1_port_out, bus10.muxnx1_port_err);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b1 || bus16.muxnx1_port_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out=%b err=%b, want out=1 err=0",
                     bus16.muxnx1_port_out, bus16.muxnx1_port_err);
        end
    endtask

    task automatic test_walking_select();
        logic exp_out;
        bus16.muxnx1_port_i = 16'h0004;
        for (int s = 0; s < 16; s++) begin
            bus16.muxnx1_port_sel = 4'(s);
            step();
            exp_out = (s == 2);
            checks++;
            if (bus16.muxnx1_port_out !== exp_out || bus16.muxnx1_port_err !== 1'b0) begin
                errors++;
                $display("FAIL walk_sel%0d: out=%b err=%b, want out=%b err=0",
                         s, bus16.muxnx1_port_out, bus16.muxnx1_port_err, exp_out);
            end
        end
    endtask

    task automatic test_counting_data();
        logic [15:0] val;
        logic        exp_out;
        for (int s = 0; s < 4; s++) begin
            bus16.muxnx1_port_sel = 4'(s);
            for (int v = 0; v < 16; v++) begin
                val = 16'(v);
                bus16.muxnx1_port_i = val;
                step();
                exp_out = val[s];
                checks++;
                if (bus16.muxnx1_port_out !== exp_out || bus16.muxnx1_port_err !== 1'b0) begin
                    errors++;
                    $display("FAIL count_sel%0d_i%0d: out=%b err=%b, want out=%b err=0",
                             s, v, bus16.muxnx1_port_out, bus16.muxnx1_port_err, exp_out);
                end
            end
        end
    endtask

    task automatic test_simultaneous_change();
        bus16.muxnx1_port_sel = 4'd3;
        bus16.muxnx1_port_i   = 16'h0008;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b1 || bus16.muxnx1_port_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_before: out=%b err=%b, want out=1 err=0",
                     bus16.muxnx1_port_out, bus16.muxnx1_port_err);
        end
        bus16.muxnx1_port_sel = 4'd7;
        bus16.muxnx1_port_i   = 16'h0080;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b1 || bus16.muxnx1_port_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_after: out=%b err=%b, want out=1 err=0",
                     bus16.muxnx1_port_out, bus16.muxnx1_port_err);
        end
        // Old select against new data must not be what got captured.
        bus16.muxnx1_port_sel = 4'd3;
        bus16.muxnx1_port_i   = 16'h0080;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b0) begin
            errors++;
            $display("FAIL simul_mixed: out=%b, want out=0", bus16.muxnx1_port_out);
        end
    endtask

    task automatic test_out_of_range();
        logic [3:0]  sel_v [5] = '{4'd12, 4'd9, 4'd10, 4'd15, 4'd0};
        logic [9:0]  i_v   [5] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h001};
        logic        out_v [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        err_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 5; t++) begin
            bus10.muxnx1_port_sel = sel_v[t];
            bus10.muxnx1_port_i   = i_v[t];
            step();
            checks++;
            if (bus10.muxnx1_port_out !== out_v[t] || bus10.muxnx1_port_err !== err_v[t]) begin
                errors++;
                $display("FAIL range_sel%0d: out=%b err=%b, want out=%b err=%b",
                         sel_v[t], bus10.muxnx1_port_out, bus10.muxnx1_port_err,
                         out_v[t], err_v[t]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        bus16.muxnx1_port_sel = 4'd2;
        bus16.muxnx1_port_i   = 16'h0004;
        bus10.muxnx1_port_sel = 4'd11;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_steady: out=%b, want 1", bus16.muxnx1_port_out);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b0 || bus10.muxnx1_port_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: out=%b err10=%b, want out=0 err10=0",
                     bus16.muxnx1_port_out, bus10.muxnx1_port_err);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus16.muxnx1_port_out !== 1'b1 || bus10.muxnx1_port_err !== 1'b1) begin
            errors++;
            $display("FAIL mid_resume: out=%b err10=%b, want out=1 err10=1",
                     bus16.muxnx1_port_out, bus10.muxnx1_port_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus16.muxnx1_port_sel = '0;
        bus16.muxnx1_port_i   = '0;
        bus10.muxnx1_port_sel = '0;
        bus10.muxnx1_port_i   = '0;
        #2;
        test_reset();
        test_walking_select();
        test_counting_data();
        test_simultaneous_change();
        test_out_of_range();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
